// File: rtl/clk_mgmt_pkg.sv
// Shared types and helpers for the clock-management pattern checker.
package clk_mgmt_pkg;

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} chk_state_t;

  // Pattern step: values run 0..vc+1 and wrap back to 0.
  function automatic int unsigned nxt_val(input int unsigned v, input int unsigned vc);
    return (v == vc + 32'd1) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; a same-cycle event survives the clear.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clk_data_checker.sv
// Checks a held-counter test pattern: each value held VALIDATION_COUNT+1 cycles, then +1 with wrap.
// Reports lock, a registered per-mismatch error pulse, a sticky flag and saturating counters.
module clk_data_checker
  import clk_mgmt_pkg::*;
#(
  parameter int          DATA_WIDTH       = 8,
  parameter int unsigned VALIDATION_COUNT = 3,
  parameter int          CNT_WIDTH        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_Data,
  input  logic                  i_Enable,
  input  logic                  i_Clear,
  output logic                  o_Locked,
  output logic                  o_Error,
  output logic                  o_Error_Sticky,
  output logic [CNT_WIDTH-1:0]  o_Error_Count,
  output logic [CNT_WIDTH-1:0]  o_Good_Count
);

  localparam int unsigned VMAX = VALIDATION_COUNT + 1;
  localparam int          PW   = $clog2(VMAX);

  chk_state_t            state;
  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] m_val;
  logic [PW-1:0]         m_phase;

  logic [DATA_WIDTH-1:0] nxt_d;
  logic [DATA_WIDTH-1:0] nxt_m;
  logic                  lock_ok;
  logic                  match;
  logic                  last;
  logic                  err_ev;
  logic                  good_ev;

  assign nxt_d = DATA_WIDTH'(nxt_val(32'(d_q), VALIDATION_COUNT));
  assign nxt_m = DATA_WIDTH'(nxt_val(32'(m_val), VALIDATION_COUNT));

  // A lock needs a genuine in-range step; a glitch to an out-of-range value never qualifies.
  assign lock_ok = i_Enable && (i_Data != d_q) && (i_Data == nxt_d) && (32'(i_Data) <= VMAX);
  assign match   = (i_Data == m_val);
  assign last    = (m_phase == PW'(VALIDATION_COUNT));
  assign err_ev  = (state == TRACK) && i_Enable && !match;
  assign good_ev = (state == TRACK) && i_Enable && match && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SYNC;
      d_q            <= '0;
      m_val          <= '0;
      m_phase        <= '0;
      o_Error        <= 1'b0;
      o_Error_Sticky <= 1'b0;
    end else begin
      d_q     <= i_Data;
      o_Error <= err_ev;
      if (i_Clear) begin
        o_Error_Sticky <= err_ev;
      end else if (err_ev) begin
        o_Error_Sticky <= 1'b1;
      end
      case (state)
        SYNC: begin
          if (lock_ok) begin
            m_val   <= i_Data;
            m_phase <= PW'(1);
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (!i_Enable) begin
            state <= SYNC;
          end else if (match) begin
            if (last) begin
              m_phase <= '0;
              m_val   <= nxt_m;
            end else begin
              m_phase <= m_phase + 1'b1;
            end
          end else begin
            state <= SYNC;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  assign o_Locked = (state == TRACK);

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_ev),
    .clr   (i_Clear),
    .count (o_Error_Count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (good_ev),
    .clr   (i_Clear),
    .count (o_Good_Count)
  );

endmodule

// File: tb/tb_clk_data_checker.sv
// Scoreboard bench: a pattern generator plus fault injection drives the checker; a run-length
// reference model predicts every cycle's outputs, which a separate monitor compares.
module tb_clk_data_checker;

  localparam int DW = 8;
  localparam int VC = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data = '0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          locked, err, sticky;
  logic [CW-1:0] ecnt, gcnt;

  clk_data_checker #(.DATA_WIDTH(DW), .VALIDATION_COUNT(VC), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_Data         (data),
    .i_Enable       (en),
    .i_Clear        (clr),
    .o_Locked       (locked),
    .o_Error        (err),
    .o_Error_Sticky (sticky),
    .o_Error_Count  (ecnt),
    .o_Good_Count   (gcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int err;
    int sticky;
    int ecnt;
    int gcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
  endfunction

  function automatic int nxt(input int v);
    return (v == VC + 1) ? 0 : v + 1;
  endfunction

  // Reference model: expected value and how many cycles of it have been seen so far.
  int m_locked = 0, m_exp = 0, m_held = 0, m_prev = 0;
  int m_sticky = 0, m_ecnt = 0, m_gcnt = 0;
  localparam int CMAX = (1 << CW) - 1;

  task automatic do_cycle(input int d, input bit e, input bit c, input bit r);
    exp_t x;
    int   ev_err;
    int   ev_good;
    @(negedge clk);
    data = d[DW-1:0];
    en   = e;
    clr  = c;
    rst  = r;
    ev_err  = 0;
    ev_good = 0;
    if (r) begin
      m_locked = 0; m_exp = 0; m_held = 0; m_prev = 0;
      m_sticky = 0; m_ecnt = 0; m_gcnt = 0;
    end else begin
      if (!m_locked) begin
        if (e && d != m_prev && d == nxt(m_prev) && d <= VC + 1) begin
          m_locked = 1; m_exp = d; m_held = 1;
        end
      end else if (!e) begin
        m_locked = 0;
      end else if (d == m_exp) begin
        m_held++;
        if (m_held == VC + 1) begin
          ev_good = 1; m_exp = nxt(m_exp); m_held = 0;
        end
      end else begin
        ev_err = 1; m_locked = 0;
      end
      if (c) begin
        m_ecnt = ev_err; m_gcnt = ev_good; m_sticky = ev_err;
      end else begin
        if (ev_err && m_ecnt < CMAX) m_ecnt++;
        if (ev_good && m_gcnt < CMAX) m_gcnt++;
        if (ev_err) m_sticky = 1;
      end
      m_prev = d;
    end
    x.locked = m_locked; x.err = ev_err; x.sticky = m_sticky;
    x.ecnt = m_ecnt; x.gcnt = m_gcnt;
    exp_q.push_back(x);
  endtask

  // Monitor: every clock edge after a stimulus cycle, compare the DUT against the queued prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("sb_locked", int'(locked), x.locked);
        chk("sb_error", int'(err), x.err);
        chk("sb_sticky", int'(sticky), x.sticky);
        chk("sb_err_count", int'(ecnt), x.ecnt);
        chk("sb_good_count", int'(gcnt), x.gcnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int g_val = 0, g_cnt = 0;

  task automatic gen_next(output int d);
    d = g_val;
    g_cnt++;
    if (g_cnt == VC + 1) begin
      g_cnt = 0;
      g_val = nxt(g_val);
    end
  endtask

  // Outputs after the most recently issued cycle, for directed spot checks.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_clean(input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      gen_next(d);
      do_cycle(d, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic advance_to(input int v, input int c);
    int d;
    for (int k = 0; k < 64 && !(g_val == v && g_cnt == c); k++) begin
      gen_next(d);
      do_cycle(d, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int d;
    bit r, e, c;

    do_cycle(0, 1'b0, 1'b0, 1'b1);
    do_cycle(0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("reset_locked", int'(locked), 0);
    chk("reset_count", int'(ecnt) + int'(gcnt) + int'(sticky) + int'(err), 0);

    // Clean stream from reset: 0000 1111 2222 3333 4444 0000
    for (int i = 0; i < 24; i++) begin
      gen_next(d);
      do_cycle(d, 1'b1, 1'b0, 1'b0);
      if (i == 3 || i == 4) begin
        settle();
        chk("lock_on_first_step", int'(locked), (i == 4) ? 1 : 0);
      end
    end
    settle();
    chk("clean_good_5", int'(gcnt), 5);
    chk("clean_no_err", int'(ecnt), 0);
    run_clean(20);
    settle();
    chk("wrap_good_10", int'(gcnt), 10);

    // Short hold: 2,2,2 then an early 3
    advance_to(2, 0);
    run_clean(3);
    g_val = 3; g_cnt = 0;
    run_clean(1);
    settle();
    chk("short_err_pulse", int'(err), 1);
    chk("short_err_count", int'(ecnt), 1);
    chk("short_unlocked", int'(locked), 0);
    run_clean(20);
    settle();
    chk("short_relock", int'(locked), 1);

    // Single-cycle glitch to an out-of-range value
    advance_to(2, 1);
    gen_next(d);
    do_cycle(7, 1'b1, 1'b0, 1'b0);
    settle();
    chk("glitch_err_count", int'(ecnt), 2);
    chk("glitch_unlocked", int'(locked), 0);
    run_clean(2);
    settle();
    chk("glitch_no_lock_yet", int'(locked), 0);
    run_clean(20);
    settle();
    chk("glitch_relock", int'(locked), 1);

    // Clear colliding with a mismatch, then a clear on its own
    advance_to(2, 2);
    gen_next(d);
    do_cycle(7, 1'b1, 1'b1, 1'b0);
    settle();
    chk("collide_err_count", int'(ecnt), 1);
    chk("collide_sticky", int'(sticky), 1);
    gen_next(d);
    do_cycle(d, 1'b1, 1'b1, 1'b0);
    settle();
    chk("clear_err_count", int'(ecnt), 0);
    chk("clear_sticky", int'(sticky), 0);
    run_clean(20);

    // Reset pulsed mid-track
    for (int i = 0; i < 3; i++) begin
      gen_next(d);
      do_cycle(d, 1'b1, 1'b0, 1'b1);
    end
    settle();
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_good", int'(gcnt), 0);
    run_clean(12);
    settle();
    chk("midrst_relock", int'(locked), 1);

    // Enable low for 10 cycles
    for (int i = 0; i < 10; i++) begin
      gen_next(d);
      do_cycle(d, 1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("disable_unlocked", int'(locked), 0);
    chk("disable_no_err", int'(ecnt), 0);
    run_clean(12);

    // Randomised faults: corrupt values, slipped holds, clears, enable drops and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) g_cnt = $urandom_range(0, VC);
      gen_next(d);
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 9);
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 39) != 0);
      c = ($urandom_range(0, 49) == 0);
      do_cycle(d, e, c, r);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
